csr_bank: RTL and testbench

Parametrised CSR register bank; successor to the accelerator's fixed-map CSR block. It serves a valid/ready request channel with byte strobes and drives a decoupled, FIFO-buffered response channel. Back-to-back requests are accepted while earlier responses are still stalled. Each register has a per-register access type (RW, RO, W1C-sticky, WO-pulse) selected by parameter masks, and illegal accesses return an error response. It sits between the host bus adapter and the core control logic, replacing hand-decoded register sets.

---
 rtl/csr_bank.sv | 200 ++++++++++++++++++++
 tb/tb_csr_bank.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_bank.sv
// Parametrised CSR register bank: valid/ready request channel with byte strobes, per-register
// access types (RW, RO, W1C-sticky, WO-pulse) and an in-order, FIFO-buffered response channel.
module csr_bank #(
  parameter int unsigned        NumRegs      = 16,
  parameter int unsigned        CsrDataWidth = 32,
  parameter int unsigned        CsrAddrWidth = 32,
  parameter int unsigned        RspFifoDepth = 4,
  parameter logic [NumRegs-1:0] RoMask       = '0,
  parameter logic [NumRegs-1:0] W1cMask      = '0,
  parameter logic [NumRegs-1:0] WoMask       = '0
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [CsrAddrWidth-1:0]         csr_req_addr_i,
  input  logic [CsrDataWidth-1:0]         csr_req_data_i,
  input  logic [CsrDataWidth/8-1:0]       csr_req_strb_i,
  input  logic                            csr_req_write_i,
  input  logic                            csr_req_valid_i,
  output logic                            csr_req_ready_o,
  output logic [CsrDataWidth-1:0]         csr_rsp_data_o,
  output logic                            csr_rsp_err_o,
  output logic                            csr_rsp_valid_o,
  input  logic                            csr_rsp_ready_i,
  output logic [NumRegs*CsrDataWidth-1:0] reg_q_o,
  output logic [NumRegs-1:0]              reg_wr_pulse_o,
  output logic [CsrDataWidth-1:0]         reg_wr_data_o,
  input  logic [NumRegs*CsrDataWidth-1:0] hw_rd_data_i,
  input  logic [NumRegs*CsrDataWidth-1:0] hw_set_i
);

  localparam int unsigned StrbWidth = CsrDataWidth / 8;
  localparam int unsigned PtrWidth  = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
  localparam int unsigned CntWidth  = $clog2(RspFifoDepth + 1);
  localparam int unsigned EntWidth  = CsrDataWidth + 1;

  // Register storage
  logic [CsrDataWidth-1:0] r_q   [NumRegs];
  logic [CsrDataWidth-1:0] w_q_d [NumRegs];

  // Request decode
  logic [NumRegs-1:0]      w_sel;
  logic                    w_hit;
  logic                    w_err;
  logic                    w_acc;
  logic                    w_wr;
  logic [CsrDataWidth-1:0] w_bmask;
  logic [CsrDataWidth-1:0] w_wdata_m;
  logic [CsrDataWidth-1:0] w_rdata;
  logic [CsrDataWidth-1:0] w_rsp_data;
  logic [EntWidth-1:0]     w_ent;

  // Response FIFO
  logic [EntWidth-1:0]     r_mem [RspFifoDepth];
  logic [PtrWidth-1:0]     r_rd_ptr;
  logic [PtrWidth-1:0]     r_wr_ptr;
  logic [CntWidth-1:0]     r_count;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;

  // Write side-band
  logic [NumRegs-1:0]      r_wr_pulse;
  logic [CsrDataWidth-1:0] r_wr_data;

  // Non-W1C hw_set bits and non-RO hw_rd bits are intentionally ignored.
  logic w_unused_inputs;
  assign w_unused_inputs = ^{hw_set_i, hw_rd_data_i};

  always_comb begin
    w_bmask = '0;
    for (int b = 0; b < StrbWidth; b++) begin
      w_bmask[b*8 +: 8] = {8{csr_req_strb_i[b]}};
    end
  end

  assign w_wdata_m = csr_req_data_i & w_bmask;

  // Full-width compare so out-of-range addresses never alias onto a register.
  always_comb begin
    w_sel = '0;
    for (int unsigned r = 0; r < NumRegs; r++) begin
      w_sel[r] = (csr_req_addr_i == CsrAddrWidth'(r));
    end
  end

  assign w_hit = |w_sel;
  assign w_err = !w_hit | (csr_req_write_i & |(w_sel & RoMask));

  always_comb begin
    w_rdata = '0;
    for (int r = 0; r < NumRegs; r++) begin
      if (w_sel[r]) begin
        if (RoMask[r]) begin
          w_rdata = hw_rd_data_i[r*CsrDataWidth +: CsrDataWidth];
        end else if (!WoMask[r]) begin
          w_rdata = r_q[r];
        end
      end
    end
  end

  assign w_rsp_data = (csr_req_write_i | w_err) ? '0 : w_rdata;
  assign w_ent      = {w_err, w_rsp_data};

  assign w_full          = (r_count == CntWidth'(RspFifoDepth));
  assign w_empty         = (r_count == '0);
  assign csr_req_ready_o = !w_full | csr_rsp_ready_i;
  assign w_acc           = csr_req_valid_i & csr_req_ready_o;
  assign w_push          = w_acc;
  assign w_pop           = !w_empty & csr_rsp_ready_i;
  assign w_wr            = w_acc & csr_req_write_i & !w_err;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    if (p == PtrWidth'(RspFifoDepth - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_ent;
    end
  end

  assign csr_rsp_valid_o                 = !w_empty;
  assign {csr_rsp_err_o, csr_rsp_data_o} = w_empty ? '0 : r_mem[r_rd_ptr];

  always_comb begin
    for (int r = 0; r < NumRegs; r++) begin
      w_q_d[r] = r_q[r];
      if (RoMask[r] || WoMask[r]) begin
        w_q_d[r] = '0;
      end else if (W1cMask[r]) begin
        // Set is OR-ed in after the clear so a coincident set wins.
        w_q_d[r] = (r_q[r] & ~((w_wr && w_sel[r]) ? w_wdata_m : '0))
                   | hw_set_i[r*CsrDataWidth +: CsrDataWidth];
      end else if (w_wr && w_sel[r]) begin
        w_q_d[r] = (r_q[r] & ~w_bmask) | w_wdata_m;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NumRegs; r++) begin
        r_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NumRegs; r++) begin
        r_q[r] <= w_q_d[r];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_pulse <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_pulse <= w_wr ? w_sel : '0;
      if (w_wr) begin
        r_wr_data <= w_wdata_m;
      end
    end
  end

  assign reg_wr_pulse_o = r_wr_pulse;
  assign reg_wr_data_o  = r_wr_data;

  always_comb begin
    reg_q_o = '0;
    for (int r = 0; r < NumRegs; r++) begin
      reg_q_o[r*CsrDataWidth +: CsrDataWidth] = r_q[r];
    end
  end

endmodule

// File: tb/tb_csr_bank.sv
// Self-checking bench for csr_bank: directed scenarios plus randomized traffic checked against
// a transaction-level register/response model.
module tb_csr_bank;

  localparam int NR    = 16;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam logic [NR-1:0] RO  = 16'h0002;
  localparam logic [NR-1:0] W1C = 16'h0008;
  localparam logic [NR-1:0] WO  = 16'h0020;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_data;
  logic [DW/8-1:0]   req_strb;
  logic              req_write;
  logic              req_valid;
  logic              req_ready;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [NR*DW-1:0]  reg_q;
  logic [NR-1:0]     pulse;
  logic [DW-1:0]     wr_data;
  logic [NR*DW-1:0]  hw_rd;
  logic [NR*DW-1:0]  hw_set;

  always #5 clk = ~clk;

  csr_bank #(
    .NumRegs     (NR),
    .CsrDataWidth(DW),
    .CsrAddrWidth(AW),
    .RspFifoDepth(DEPTH),
    .RoMask      (RO),
    .W1cMask     (W1C),
    .WoMask      (WO)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .csr_req_addr_i (req_addr),
    .csr_req_data_i (req_data),
    .csr_req_strb_i (req_strb),
    .csr_req_write_i(req_write),
    .csr_req_valid_i(req_valid),
    .csr_req_ready_o(req_ready),
    .csr_rsp_data_o (rsp_data),
    .csr_rsp_err_o  (rsp_err),
    .csr_rsp_valid_o(rsp_valid),
    .csr_rsp_ready_i(rsp_ready),
    .reg_q_o        (reg_q),
    .reg_wr_pulse_o (pulse),
    .reg_wr_data_o  (wr_data),
    .hw_rd_data_i   (hw_rd),
    .hw_set_i       (hw_set)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: register contents, pending responses {err, data}.
  logic [DW-1:0] m_q [NR];
  logic [DW:0]   mq[$];
  logic [DW:0]   exp_q[$];
  logic [DW:0]   obs_q[$];
  logic [NR-1:0] exp_pulse;
  logic [DW-1:0] exp_wdata;
  logic          exp_ready;
  logic          obs_ready;

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int r = 0; r < NR; r++) f[r*DW +: DW] = m_q[r];
    return f;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NR; r++) m_q[r] = '0;
    mq.delete();
    exp_q.delete();
    obs_q.delete();
    exp_pulse = '0;
    exp_wdata = '0;
  endtask

  // Called at a negedge with inputs already driven; advances model and DUT by one clock.
  task automatic step();
    logic [DW:0]   e;
    logic [DW-1:0] bm;
    logic          acc;
    int            a;
    #1;
    exp_ready = (mq.size() < DEPTH) || rsp_ready;
    obs_ready = req_ready;
    acc       = req_valid && exp_ready;
    if (rsp_ready && rsp_valid) obs_q.push_back({rsp_err, rsp_data});
    if (rsp_ready && mq.size() > 0) exp_q.push_back(mq.pop_front());
    for (int b = 0; b < DW / 8; b++) bm[b*8 +: 8] = {8{req_strb[b]}};
    exp_pulse = '0;
    if (acc) begin
      a = int'(req_addr[3:0]);
      if (req_addr >= NR || (req_write && RO[a])) begin
        e = {1'b1, {DW{1'b0}}};
      end else if (req_write) begin
        e = '0;
        exp_pulse[a] = 1'b1;
        exp_wdata    = req_data & bm;
        if (W1C[a]) m_q[a] = m_q[a] & ~(req_data & bm);
        else if (!WO[a]) m_q[a] = (m_q[a] & ~bm) | (req_data & bm);
      end else if (RO[a]) begin
        e = {1'b0, hw_rd[a*DW +: DW]};
      end else if (WO[a]) begin
        e = '0;
      end else begin
        e = {1'b0, m_q[a]};
      end
      mq.push_back(e);
    end
    for (int r = 0; r < NR; r++) if (W1C[r]) m_q[r] = m_q[r] | hw_set[r*DW +: DW];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input int addr, input logic [DW-1:0] data, input logic [3:0] strb,
                     input logic wr);
    req_addr  = AW'(addr);
    req_data  = data;
    req_strb  = strb;
    req_write = wr;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (!rsp_valid && mq.size() == 0) break;
      step();
    end
  endtask

  task automatic test_reset();
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    n_vec++; if (rsp_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", rsp_data); end
    n_vec++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", rsp_err); end
    n_vec++; if (pulse !== '0) begin n_bad++; $display("FAIL reset_pulse: got %h want 0", pulse); end
    n_vec++; if (wr_data !== '0) begin n_bad++; $display("FAIL reset_wrdata: got %h want 0", wr_data); end
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_vec++; if (reg_q !== '0) begin n_bad++; $display("FAIL reset_regq: got %h want 0", reg_q); end
  endtask

  task automatic test_rw();
    logic [DW:0] e;
    rsp_ready = 1'b1;
    req(2, 32'hDEADBEEF, 4'b0101, 1'b1);
    n_vec++; if (pulse !== 16'h0004) begin n_bad++; $display("FAIL rw_pulse: got %h want 0004", pulse); end
    n_vec++; if (wr_data !== 32'h00AD00EF) begin n_bad++; $display("FAIL rw_wrdata: got %h want 00ad00ef", wr_data); end
    req(2, 32'h0, 4'h0, 1'b0);
    n_vec++; if (pulse !== '0) begin n_bad++; $display("FAIL rw_pulse_width: got %h want 0", pulse); end
    n_vec++; if (reg_q[2*DW +: DW] !== 32'h00AD00EF) begin n_bad++; $display("FAIL rw_regq: got %h want 00ad00ef", reg_q[2*DW +: DW]); end
    drain();
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rw_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    e = (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : '1;
    n_vec++; if (e !== {1'b0, 32'h00AD00EF}) begin n_bad++; $display("FAIL rw_read: got %h want 000ad00ef", e); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [DW:0] o = obs_q.pop_front();
      logic [DW:0] x = exp_q.pop_front();
      n_vec++; if (o !== x) begin n_bad++; $display("FAIL rw_rsp: got %h want %h", o, x); end
    end
  endtask

  task automatic test_err();
    logic [NR*DW-1:0] snap;
    snap = reg_q;
    req(NR, 32'h0, 4'h0, 1'b0);
    n_vec++; if (pulse !== '0) begin n_bad++; $display("FAIL err_oob_pulse: got %h want 0", pulse); end
    req(1, 32'h12345678, 4'hF, 1'b1);
    n_vec++; if (pulse !== '0) begin n_bad++; $display("FAIL err_ro_pulse: got %h want 0", pulse); end
    n_vec++; if (reg_q !== snap) begin n_bad++; $display("FAIL err_regq: got %h want %h", reg_q, snap); end
    drain();
    n_vec++; if (obs_q.size() !== 2) begin n_bad++; $display("FAIL err_count: got %0d want 2", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [DW:0] o = obs_q.pop_front();
      void'(exp_q.pop_front());
      n_vec++; if (o !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL err_rsp: got %h want 100000000", o); end
    end
  endtask

  task automatic test_w1c();
    logic [DW:0] want [5];
    want[0] = {1'b0, 32'h5}; want[1] = '0; want[2] = {1'b0, 32'h4};
    want[3] = '0;            want[4] = {1'b0, 32'h5};
    rsp_ready = 1'b1;
    hw_set[3*DW +: DW] = 32'h5;
    step();
    hw_set[3*DW +: DW] = 32'h0;
    n_vec++; if (reg_q[3*DW +: DW] !== 32'h5) begin n_bad++; $display("FAIL w1c_set: got %h want 5", reg_q[3*DW +: DW]); end
    req(3, 32'h0, 4'h0, 1'b0);
    req(3, 32'h1, 4'hF, 1'b1);
    n_vec++; if (pulse !== 16'h0008) begin n_bad++; $display("FAIL w1c_pulse: got %h want 0008", pulse); end
    req(3, 32'h0, 4'h0, 1'b0);
    hw_set[3*DW +: DW] = 32'h1;
    req(3, 32'h1, 4'hF, 1'b1);
    hw_set[3*DW +: DW] = 32'h0;
    req(3, 32'h0, 4'h0, 1'b0);
    drain();
    n_vec++; if (obs_q.size() !== 5) begin n_bad++; $display("FAIL w1c_count: got %0d want 5", obs_q.size()); end
    for (int i = 0; i < 5 && obs_q.size() > 0; i++) begin
      logic [DW:0] o = obs_q.pop_front();
      n_vec++; if (o !== want[i]) begin n_bad++; $display("FAIL w1c_rsp%0d: got %h want %h", i, o, want[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [DW:0] head;
    rsp_ready = 1'b0;
    req_write = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_addr = AW'(i);
      step();
      n_vec++; if (obs_ready !== (i < 4)) begin n_bad++; $display("FAIL bp_ready%0d: got %b want %b", i, obs_ready, (i < 4)); end
      if (i == 1) head = {rsp_err, rsp_data};
      if (i > 1) begin
        n_vec++; if ({rsp_err, rsp_data} !== head) begin n_bad++; $display("FAIL bp_hold%0d: got %h want %h", i, {rsp_err, rsp_data}, head); end
      end
    end
    // Release: pending four drain while the two refused reads are re-offered.
    rsp_ready = 1'b1;
    for (int i = 4; i < 6; i++) begin
      req_addr = AW'(i);
      step();
      n_vec++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL bp_retry%0d: got %b want 1", i, obs_ready); end
    end
    drain();
    n_vec++; if (obs_q.size() !== 6) begin n_bad++; $display("FAIL bp_count: got %0d want 6", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [DW:0] o = obs_q.pop_front();
      logic [DW:0] x = exp_q.pop_front();
      n_vec++; if (o !== x) begin n_bad++; $display("FAIL bp_rsp: got %h want %h", o, x); end
    end
  endtask

  task automatic test_full_pushpop();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) req(i, 32'h0, 4'h0, 1'b0);
    rsp_ready = 1'b1;
    req(2, 32'h0, 4'h0, 1'b0);
    n_vec++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL full_accept: got %b want 1", obs_ready); end
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    #1;
    n_vec++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL full_count: got ready %b want 0", req_ready); end
    req_valid = 1'b0;
    drain();
    n_vec++; if (obs_q.size() !== 5) begin n_bad++; $display("FAIL full_total: got %0d want 5", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [DW:0] o = obs_q.pop_front();
      logic [DW:0] x = exp_q.pop_front();
      n_vec++; if (o !== x) begin n_bad++; $display("FAIL full_rsp: got %h want %h", o, x); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = AW'($urandom_range(0, NR + 1));
      req_write = $urandom_range(0, 1) == 1;
      req_data  = $urandom;
      req_strb  = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < NR; r++) hw_rd[r*DW +: DW] = $urandom;
      hw_set = '0;
      if ($urandom_range(0, 3) == 0) hw_set[3*DW +: DW] = $urandom & $urandom;
      hw_set[2*DW +: DW] = $urandom;
      step();
      n_vec++; if (obs_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready%0d: got %b want %b", n, obs_ready, exp_ready); end
      n_vec++; if (reg_q !== model_flat()) begin n_bad++; $display("FAIL rnd_regq%0d: got %h want %h", n, reg_q, model_flat()); end
      n_vec++; if (pulse !== exp_pulse) begin n_bad++; $display("FAIL rnd_pulse%0d: got %h want %h", n, pulse, exp_pulse); end
      n_vec++; if (wr_data !== exp_wdata) begin n_bad++; $display("FAIL rnd_wrdata%0d: got %h want %h", n, wr_data, exp_wdata); end
    end
    hw_set = '0;
    drain();
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [DW:0] o = obs_q.pop_front();
      logic [DW:0] x = exp_q.pop_front();
      n_vec++; if (o !== x) begin n_bad++; $display("FAIL rnd_rsp: got %h want %h", o, x); end
    end
  endtask

  task automatic test_reset_mid();
    req(0, 32'hA5A5A5A5, 4'hF, 1'b1);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) req(i, 32'h0, 4'h0, 1'b0);
    rst_ni = 1'b0;
    #2;
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    n_vec++; if (reg_q !== '0) begin n_bad++; $display("FAIL rst_regq: got %h want 0", reg_q); end
    @(negedge clk);
    rst_ni = 1'b1;
    model_clear();
    rsp_ready = 1'b1;
    step();
    step();
    n_vec++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL rst_stale: got %0d responses want 0", obs_q.size()); end
  endtask

  initial begin
    rst_ni    = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_strb  = '0;
    req_write = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    hw_rd     = '0;
    hw_set    = '0;
    model_clear();
    repeat (2) @(negedge clk);
    test_reset();
    rst_ni = 1'b1;
    @(negedge clk);
    test_rw();
    test_err();
    test_w1c();
    test_backpressure();
    test_full_pushpop();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
